multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port run, input, 1 bit: when high, permits a new instruction fetch.
REQ-004 SHALL have port instr, input, 32 bits: current instruction register contents from the datapath.
REQ-005 SHALL have ports mem_write, reg_write, ir_write and pc_write, each an output of 1 bit: datapath write enables.
REQ-006 SHALL have port instruction_or_data, output, 1 bit: address select; 0 selects pc, 1 selects result.
REQ-007 SHALL have port result_src, output, 2 bits: result mux select; 00 selects alu_out, 01 selects read data, 10 selects alu_result.
REQ-008 SHALL have ports alu_src_a and alu_src_b, each an output of 2 bits: operand selects; a: 00 selects pc, 01 selects rs1; b: 00 selects rs2, 01 selects 4, 10 selects immediate.
REQ-009 SHALL have port alu_control, output, 3 bits: 000 ADD, 001 SUB.
REQ-010 SHALL have port state, output, 4 bits: current FSM state encoding.
REQ-011 SHALL have port retire, output, 1 bit: one-cycle pulse in the final cycle of a legal instruction.
REQ-012 SHALL have port retired_count, output, 32 bits: count of retired instructions.
REQ-013 SHALL have port illegal, output, 1 bit: sticky flag set when an illegal opcode is decoded.

Function
REQ-014 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB and HALT.
REQ-015 FETCH with run=1: ir_write=1, instruction_or_data=0, alu_src_a=00, alu_src_b=01, ADD; next state DECODE.
REQ-016 FETCH with run=0: all write enables 0; remain in FETCH.
REQ-017 DECODE: pc_write=1 (pc<=pc+4 held in alu_out); next state chosen by instr[6:0]: 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, any other opcode is illegal.
REQ-018 MEMADR: alu_src_a=01, alu_src_b=10, ADD; next state MEMREAD if opcode is 0000011, else MEMWRITE.
REQ-019 MEMREAD: instruction_or_data=1, result_src=00; next state MEMWB.
REQ-020 MEMWB: result_src=01, reg_write=1, retire=1; next state FETCH.
REQ-021 MEMWRITE: mem_write=1, retire=1; next state FETCH.
REQ-022 EXECR: alu_src_a=01, alu_src_b=00; SUB when funct3=000 and instr[30]=1, else ADD; next state ALUWB.
REQ-023 EXECI: alu_src_a=01, alu_src_b=10, ADD; next state ALUWB.
REQ-024 ALUWB: result_src=00, reg_write=1, retire=1; next state FETCH.
REQ-025 Latency SHALL be lw 5 cycles, and sw, R-type and I-type 4 cycles each, with no bubble before the next FETCH.
REQ-026 All outputs not listed for a state SHALL be 0 in that state.
REQ-027 At most one of mem_write and reg_write SHALL be high in any cycle.
REQ-028 retired_count SHALL increment by 1 on each retire and wrap from 0xFFFFFFFF to 0.
REQ-029 Deasserting run mid-instruction SHALL NOT stall the instruction; run is sampled only in FETCH.

Reset
REQ-030 While reset=0 at a clk edge: state<=FETCH, retired_count<=0, illegal<=0.
REQ-031 While reset=0, all write-enable outputs and retire SHALL be 0.
REQ-032 Reset asserted mid-instruction SHALL abort that instruction with no further writes.

Configuration
REQ-033 Macro CTRL_ILLEGAL_TRAP_EN, when defined: an illegal opcode in DECODE sets illegal and moves to HALT, which is left only by reset, with all outputs 0.
REQ-034 Without CTRL_ILLEGAL_TRAP_EN: an illegal opcode sets illegal, returns to FETCH as a NOP with no retire, and pc is still advanced.

Structure
REQ-035 Shared package ctrl_pkg SHALL hold the state encodings, opcode constants, ALU codes and mux select codes.
REQ-036 ALU control decode SHALL be in sub-module alu_decoder (inputs opcode, funct3, instr[30] and an ALU-op class; output alu_control).

Verification
REQ-037 Reset, then run=1 with lw (0x00402083) -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write high only in cycle 5; retired_count=1.
REQ-038 sw (0x00112223) -> mem_write high in cycle 4 only; no reg_write; 4 cycles to FETCH.
REQ-039 sub (0x40208133) -> alu_control=001 in EXECR; add (0x00208133) -> 000.
REQ-040 run=0 for 10 cycles -> state stays FETCH, ir_write=0, retired_count unchanged.
REQ-041 Opcode 0x7F -> illegal=1; with the macro, state HALT until reset; without it, back to FETCH after 2 cycles with no retire.
REQ-042 reset=0 asserted in MEMREAD -> next cycle FETCH, no reg_write, retired_count=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// ALU codes, datapath mux select codes and the control-word bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    HALT     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001
  } alu_ctrl_t;

  // ALU-op class: force an add, or let the instruction's function fields decide.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       instruction_or_data;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       retire;
  } ctrl_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_ITYPE);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath side.
interface multicycle_controller_if;
  logic        run;
  logic [31:0] instr;
  logic        mem_write;
  logic        reg_write;
  logic        ir_write;
  logic        pc_write;
  logic        instruction_or_data;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic        retire;
  logic [31:0] retired_count;
  logic        illegal;

  modport master (
    input  run, instr,
    output mem_write, reg_write, ir_write, pc_write, instruction_or_data,
           result_src, alu_src_a, alu_src_b, alu_control, state, retire,
           retired_count, illegal
  );

  modport slave (
    output run, instr,
    input  mem_write, reg_write, ir_write, pc_write, instruction_or_data,
           result_src, alu_src_a, alu_src_b, alu_control, state, retire,
           retired_count, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU control decode: SUB only for an R-type with funct3=000 and instr[30]=1,
// and only when the FSM asks for a function-field decode; ADD otherwise.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       instr_30,
  input  alu_op_t    alu_op,
  output alu_ctrl_t  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    if (alu_op == ALU_OP_FUNCT && opcode == OP_RTYPE && funct3 == 3'b000 && instr_30)
      alu_control = ALU_SUB;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller (lw/sw/R-type/I-type) with retire counter.
// Define CTRL_ILLEGAL_TRAP_EN to halt on an illegal opcode instead of skipping it.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  multicycle_controller_if.master        bus
);

  state_t      state_q, state_d;
  logic [31:0] count_q;
  logic        illegal_q;
  logic        illegal_set;
  ctrl_t       ctrl;
  alu_op_t     alu_op;
  alu_ctrl_t   alu_control;
  logic [6:0]  opcode;
  logic        unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (bus.instr[14:12]),
    .instr_30    (bus.instr[30]),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ctrl        = '0;
    alu_op      = ALU_OP_ADD;
    illegal_set = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.run) begin
          ctrl.ir_write  = 1'b1;
          ctrl.alu_src_a = SRC_A_PC;
          ctrl.alu_src_b = SRC_B_FOUR;
          state_d        = DECODE;
        end
      end
      DECODE: begin
        // pc+4 was computed during FETCH and sits in alu_out; commit it for every opcode.
        ctrl.pc_write = 1'b1;
        if (!is_legal_opcode(opcode)) begin
          illegal_set = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d     = HALT;
`else
          state_d     = FETCH;
`endif
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = EXECR;
        end else begin
          state_d = EXECI;
        end
      end
      MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        ctrl.instruction_or_data = 1'b1;
        ctrl.result_src          = RES_ALU_OUT;
        state_d                  = MEMWB;
      end
      MEMWB: begin
        ctrl.result_src = RES_READ_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        state_d         = FETCH;
      end
      MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = FETCH;
      end
      EXECR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        alu_op         = ALU_OP_FUNCT;
        state_d        = ALUWB;
      end
      EXECI: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = ALUWB;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALU_OUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        state_d         = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl.retire) count_q <= count_q + 32'd1;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  // Reset is synchronous, so the state may still be mid-instruction while reset
  // is low; gate the strobes so an aborted instruction writes nothing.
  assign bus.mem_write           = ctrl.mem_write & reset;
  assign bus.reg_write           = ctrl.reg_write & reset;
  assign bus.ir_write            = ctrl.ir_write  & reset;
  assign bus.pc_write            = ctrl.pc_write  & reset;
  assign bus.retire              = ctrl.retire    & reset;
  assign bus.instruction_or_data = ctrl.instruction_or_data;
  assign bus.result_src          = ctrl.result_src;
  assign bus.alu_src_a           = ctrl.alu_src_a;
  assign bus.alu_src_b           = ctrl.alu_src_b;
  assign bus.alu_control         = alu_control;
  assign bus.state               = state_q;
  assign bus.retired_count       = count_q;
  assign bus.illegal             = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: an instruction-level model expands each fetched
// instruction into its expected per-cycle control words; directed cases pin it.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  localparam logic [31:0] I_LW   = 32'h00402083;
  localparam logic [31:0] I_SW   = 32'h00112223;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_ADD  = 32'h00208133;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  typedef struct packed {
    logic [3:0] st;
    logic       mw, rw, irw, pcw, iord, ret, ill;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
  } exp_t;

  exp_t        model_q[$];
  logic [31:0] model_count;
  logic        model_illegal;
  logic        model_halted;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t blank(input state_t s);
    exp_t e;
    e    = '0;
    e.st = s;
    return e;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011;
  endfunction

  // One instruction -> the list of control words it must produce, one per cycle.
  function automatic void expand(input logic [31:0] ins);
    exp_t e;
    logic [6:0] op;
    op = ins[6:0];
    e = blank(FETCH);  e.irw = 1; e.sb = 2'b01;       model_q.push_back(e);
    e = blank(DECODE); e.pcw = 1; e.ill = !legal(op); model_q.push_back(e);
    if (op == 7'b0000011 || op == 7'b0100011) begin
      e = blank(MEMADR); e.sa = 2'b01; e.sb = 2'b10; model_q.push_back(e);
      if (op == 7'b0000011) begin
        e = blank(MEMREAD); e.iord = 1; model_q.push_back(e);
        e = blank(MEMWB); e.rs = 2'b01; e.rw = 1; e.ret = 1; model_q.push_back(e);
      end else begin
        e = blank(MEMWRITE); e.mw = 1; e.ret = 1; model_q.push_back(e);
      end
    end else if (op == 7'b0110011 || op == 7'b0010011) begin
      if (op == 7'b0110011) begin
        e = blank(EXECR); e.sa = 2'b01;
        e.alu = (ins[14:12] == 3'b000 && ins[30]) ? 3'b001 : 3'b000;
      end else begin
        e = blank(EXECI); e.sa = 2'b01; e.sb = 2'b10;
      end
      model_q.push_back(e);
      e = blank(ALUWB); e.rw = 1; e.ret = 1; model_q.push_back(e);
    end
  endfunction

  function automatic bit fetch_slot();
    return model_q.size() == 0 && !model_halted;
  endfunction

  // One clock: drive inputs on the falling edge, compare against the model, advance the model.
  task automatic cycle(input logic rst_n, input logic run_i, input logic [31:0] instr_i);
    exp_t e;
    @(negedge clk);
    reset     = rst_n;
    bus.run   = run_i;
    bus.instr = instr_i;
    if (model_halted) e = blank(HALT);
    else begin
      if (model_q.size() == 0) begin
        if (run_i) expand(instr_i);
        else model_q.push_back(blank(FETCH));
      end
      e = model_q.pop_front();
    end
    #1;
    check("state",     bus.state,     e.st);
    check("mem_write", bus.mem_write, rst_n ? e.mw  : 1'b0);
    check("reg_write", bus.reg_write, rst_n ? e.rw  : 1'b0);
    check("ir_write",  bus.ir_write,  rst_n ? e.irw : 1'b0);
    check("pc_write",  bus.pc_write,  rst_n ? e.pcw : 1'b0);
    check("retire",    bus.retire,    rst_n ? e.ret : 1'b0);
    if (rst_n) begin
      check("instruction_or_data", bus.instruction_or_data, e.iord);
      check("result_src",  bus.result_src,  e.rs);
      check("alu_src_a",   bus.alu_src_a,   e.sa);
      check("alu_src_b",   bus.alu_src_b,   e.sb);
      check("alu_control", bus.alu_control, e.alu);
    end
    check("write_exclusive", bus.mem_write & bus.reg_write, 1'b0);
    check("retired_count", bus.retired_count, model_count);
    check("illegal",       bus.illegal,       model_illegal);
    if (!rst_n) begin
      model_q.delete();
      model_count   = '0;
      model_illegal = 1'b0;
      model_halted  = 1'b0;
    end else begin
      if (e.ret) model_count = model_count + 32'd1;
      if (e.ill) begin
        model_illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        model_halted = 1'b1;
        model_q.delete();
`endif
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 9))
      0, 1: r[6:0] = 7'b0000011;
      2, 3: r[6:0] = 7'b0100011;
      4, 5: begin
        r[6:0] = 7'b0110011;
        if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000;
      end
      6, 7, 8: r[6:0] = 7'b0010011;
      default: while (legal(r[6:0])) r[6:0] = 7'($urandom());
    endcase
    return r;
  endfunction

  state_t lw_seq[5] = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};

  initial begin
    logic [31:0] cur_instr;
    model_q.delete();
    model_count   = '0;
    model_illegal = 1'b0;
    model_halted  = 1'b0;
    reset     = 1'b0;
    bus.run   = 1'b0;
    bus.instr = '0;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1'b0, 1'b1, '0);
    check("rst_state", bus.state, FETCH);
    check("rst_ir_write", bus.ir_write, 1'b0);
    cycle(1'b1, 1'b0, '0);
    check("rst_count", bus.retired_count, 32'd0);
    check("rst_illegal", bus.illegal, 1'b0);

    // lw: five cycles, register write only in the last
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, I_LW);
      check("lw_state", bus.state, lw_seq[i]);
      check("lw_reg_write", bus.reg_write, (i == 4));
    end
    cycle(1'b1, 1'b0, I_LW);
    check("lw_back_to_fetch", bus.state, FETCH);
    check("lw_count", bus.retired_count, 32'd1);

    // sw: four cycles, memory write only in the last
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, I_SW);
      check("sw_mem_write", bus.mem_write, (i == 3));
      check("sw_reg_write", bus.reg_write, 1'b0);
    end
    cycle(1'b1, 1'b0, I_SW);
    check("sw_back_to_fetch", bus.state, FETCH);
    check("sw_count", bus.retired_count, 32'd2);

    // sub then add, back to back; run drops mid-instruction on the sub
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, (i == 0), I_SUB);
      if (i == 2) begin
        check("sub_state", bus.state, EXECR);
        check("sub_alu", bus.alu_control, 3'b001);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, I_ADD);
      if (i == 2) check("add_alu", bus.alu_control, 3'b000);
    end
    cycle(1'b1, 1'b0, I_ADD);
    check("rtype_count", bus.retired_count, 32'd4);

    // run low: idle in FETCH
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, I_LW);
      check("idle_state", bus.state, FETCH);
      check("idle_ir_write", bus.ir_write, 1'b0);
      check("idle_count", bus.retired_count, 32'd4);
    end

    // illegal opcode
    cycle(1'b1, 1'b1, I_ILL);
    cycle(1'b1, 1'b1, I_ILL);
    check("ill_pc_write", bus.pc_write, 1'b1);
    check("ill_no_retire", bus.retire, 1'b0);
    cycle(1'b1, 1'b0, I_ILL);
    check("ill_flag", bus.illegal, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_halt", bus.state, HALT);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, I_LW);
      check("halt_stays", bus.state, HALT);
    end
`else
    check("ill_nop_fetch", bus.state, FETCH);
`endif
    check("ill_count", bus.retired_count, 32'd4);

    // reset mid-lw in MEMREAD
    cycle(1'b0, 1'b0, I_LW);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, I_LW);
    cycle(1'b0, 1'b1, I_LW);
    check("abort_in_memread", bus.state, MEMREAD);
    cycle(1'b1, 1'b0, I_LW);
    check("abort_state", bus.state, FETCH);
    check("abort_reg_write", bus.reg_write, 1'b0);
    check("abort_count", bus.retired_count, 32'd0);

    // Randomized traffic
    cur_instr = rand_instr();
    for (int n = 0; n < 3000; n++) begin
      if (fetch_slot()) cur_instr = rand_instr();
      cycle(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            cur_instr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
